// File: rtl/stack_port_requester_if.sv
// ----------------------------------------------------------------------------
// stack_port_requester_if : producer, stack-port and response signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface stack_port_requester_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic [1:0] req_cmd;

    logic       stk_in_valid;
    logic       stk_in_ready;
    logic [7:0] stk_in_data;
    logic [1:0] stk_in_cmd;

    logic       stk_out_valid;
    logic       stk_out_ready;
    logic [7:0] stk_out_data;
    logic [1:0] stk_out_cmd;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_cmd;
    logic       rsp_err;

    logic       busy;
    logic [7:0] err_cnt;

    modport master (
        input  req_valid, req_data, req_cmd,
        output req_ready,
        output stk_in_valid, stk_in_data, stk_in_cmd,
        input  stk_in_ready,
        input  stk_out_valid, stk_out_data, stk_out_cmd,
        output stk_out_ready,
        output rsp_valid, rsp_data, rsp_cmd, rsp_err,
        input  rsp_ready,
        output busy, err_cnt
    );

    modport slave (
        output req_valid, req_data, req_cmd,
        input  req_ready,
        input  stk_in_valid, stk_in_data, stk_in_cmd,
        output stk_in_ready,
        output stk_out_valid, stk_out_data, stk_out_cmd,
        input  stk_out_ready,
        input  rsp_valid, rsp_data, rsp_cmd, rsp_err,
        output rsp_ready,
        input  busy, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/stack_port_requester.sv
// ----------------------------------------------------------------------------
// stack_port_requester : FIFO-buffered, one-at-a-time client for a stack port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stack_port_requester #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    stack_port_requester_if.master bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMAX = c_TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DELIVER  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [9:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_TW-1:0] r_timer;
    logic            r_cur_pop;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_data;
    logic [1:0]      r_rsp_cmd;
    logic            r_rsp_err;
    logic [7:0]      r_err_cnt;

    logic            w_req_ready;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_head_cmd;
    logic [7:0]      w_head_data;
    logic            w_stk_in_valid;
    logic            w_hs;
    logic            w_timeout;
    logic            w_rsp_bad;
    logic            w_load;
    logic            w_accept;
    logic [7:0]      w_rsp_data_nxt;
    logic [1:0]      w_rsp_cmd_nxt;
    logic            w_rsp_err_nxt;

    assign w_req_ready    = (r_count != c_CW'(DEPTH));
    assign w_push         = bus.req_valid && w_req_ready;
    assign w_head_cmd     = r_mem[r_rd_ptr][9:8];
    assign w_head_data    = r_mem[r_rd_ptr][7:0];
    // Illegal head commands never reach the stack.
    assign w_stk_in_valid = (r_state == S_ISSUE) && !w_head_cmd[1];
    assign w_hs           = w_stk_in_valid && bus.stk_in_ready;
    assign w_timeout      = (TIMEOUT != 0) && (r_timer == c_TMAX);
    assign w_rsp_bad      = (bus.stk_out_cmd != {1'b1, r_cur_pop});

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_load         = 1'b0;
        w_accept       = 1'b0;
        w_rsp_data_nxt = 8'h00;
        w_rsp_cmd_nxt  = 2'b00;
        w_rsp_err_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_count != '0) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_head_cmd[1] || (!w_hs && w_timeout)) begin
                    w_pop         = 1'b1;
                    w_load        = 1'b1;
                    w_rsp_cmd_nxt = w_head_cmd;
                    w_rsp_err_nxt = 1'b1;
                    w_state_nxt   = S_DELIVER;
                end else if (w_hs) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (bus.stk_out_valid) begin
                    w_load         = 1'b1;
                    w_rsp_err_nxt  = w_rsp_bad;
                    w_rsp_cmd_nxt  = w_rsp_bad ? {1'b0, r_cur_pop} : bus.stk_out_cmd;
                    w_rsp_data_nxt = (!w_rsp_bad && r_cur_pop) ? bus.stk_out_data : 8'h00;
                    w_state_nxt    = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (bus.rsp_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Counts consecutive ISSUE cycles spent without a handshake.
            r_timer <= ((r_state == S_ISSUE) && (w_state_nxt == S_ISSUE)) ? r_timer + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.req_cmd, bus.req_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_cur_pop <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_hs)   r_cur_pop <= w_head_cmd[0];
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_cmd   <= 2'b00;
            r_rsp_err   <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            if (w_load) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_rsp_data_nxt;
                r_rsp_cmd   <= w_rsp_cmd_nxt;
                r_rsp_err   <= w_rsp_err_nxt;
            end else if (w_accept) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_accept && r_rsp_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.stk_in_valid  = w_stk_in_valid;
    assign bus.stk_in_data   = w_head_data;
    assign bus.stk_in_cmd    = w_head_cmd;
    assign bus.stk_out_ready = (r_state == S_WAIT_RSP);
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.rsp_cmd       = r_rsp_cmd;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.err_cnt       = r_err_cnt;

endmodule

`default_nettype wire
